// File: rtl/multi_way_traffic_controller.sv
// multi_way_traffic_controller
// N-approach traffic light controller. Approaches are served round-robin,
// idle approaches are skipped, and the controller rests in green while no
// other approach is waiting. Every yellow is followed by an all-red clearance
// interval before the next green.
//
// Interface contract: req is a level-sensitive presence vector, synchronous
// to clk, with no handshake. It is sampled on every rising edge. Only the
// GREEN->YELLOW and ALL_RED->GREEN decisions look at it, so changing req
// during YELLOW or ALL_RED never alters how long those phases last.
//
// The phase output carries the FSM state directly, so a checker can follow
// the controller without looking inside it.
module multi_way_traffic_controller #(
    parameter int N_WAYS      = 4,
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int TIMER_W     = 5,
    localparam int IDX_W      = (N_WAYS <= 2) ? 1 : $clog2(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_WAYS-1:0]     req,
    output logic [3*N_WAYS-1:0]   lights,
    output logic [IDX_W-1:0]      active_way,
    output logic [1:0]            phase
);

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALLRED  = 2'b10,
        PH_ILLEGAL = 2'b11
    } phase_e;

    // Per-approach lamp encoding, {red, yellow, green}.
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_RED    = 3'b100;

    // Last timer value of each phase; the phase ends on the edge seen at this value.
    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [IDX_W-1:0]   LAST_WAY    = IDX_W'(N_WAYS - 1);

    // Lamp pattern for a given phase/owner: only the owner may be non-red,
    // and only during GREEN or YELLOW.
    function automatic logic [3*N_WAYS-1:0] decode_lights(input phase_e ph,
                                                          input logic [IDX_W-1:0] act);
        logic [3*N_WAYS-1:0] l;
        l = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            l[3*i +: 3] = L_RED;
            if (act == IDX_W'(i)) begin
                if (ph == PH_GREEN) begin
                    l[3*i +: 3] = L_GREEN;
                end else if (ph == PH_YELLOW) begin
                    l[3*i +: 3] = L_YELLOW;
                end
            end
        end
        return l;
    endfunction

    phase_e                phase_q, phase_d;
    logic [IDX_W-1:0]      active_q, active_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [3*N_WAYS-1:0]   lights_q, lights_d;

    logic [(1<<IDX_W)-1:0] idx_legal;
    logic [N_WAYS-1:0]     active_onehot;
    logic                  others_req;
    logic [IDX_W-1:0]      fallback_way;
    logic [IDX_W-1:0]      next_way;
    logic                  next_found;

    // Table of which index encodings name a real approach (matters when
    // N_WAYS is not a power of two).
    always_comb begin
        idx_legal = '0;
        for (int j = 0; j < (1 << IDX_W); j++) begin
            idx_legal[j] = (j < N_WAYS);
        end
    end

    // Demand from any approach other than the current owner; the owner's
    // own request never keeps or ends its green.
    always_comb begin
        active_onehot = N_WAYS'(1) << active_q;
        others_req    = |(req & ~active_onehot);
    end

    // Round-robin search starting just after the owner, wrapping, and never
    // returning the owner itself. With no requester the next approach in
    // order is taken so the rotation still advances.
    always_comb begin
        int cand;
        fallback_way = (active_q == LAST_WAY) ? '0 : active_q + IDX_W'(1);
        next_way     = fallback_way;
        next_found   = 1'b0;
        cand         = 0;
        for (int k = 1; k < N_WAYS; k++) begin
            cand = int'(active_q) + k;
            if (cand >= N_WAYS) begin
                cand = cand - N_WAYS;
            end
            if (!next_found && (cand < N_WAYS) && req[cand]) begin
                next_way   = IDX_W'(cand);
                next_found = 1'b1;
            end
        end
    end

    // Phase sequencing and timer; lights are decoded from the next state so
    // the registered lamps always match the registered phase/owner.
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        timer_d  = timer_q;
        if (!idx_legal[active_q]) begin
            phase_d  = PH_GREEN;
            active_d = '0;
            timer_d  = '0;
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (timer_q >= GREEN_LAST) begin
                        if (others_req) begin
                            phase_d = PH_YELLOW;
                            timer_d = '0;
                        end else begin
                            // Rest in green: hold the timer at its last value
                            // so a new request leaves on the very next edge.
                            timer_d = GREEN_LAST;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PH_YELLOW: begin
                    if (timer_q >= YELLOW_LAST) begin
                        phase_d = PH_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PH_ALLRED: begin
                    if (timer_q >= ALLRED_LAST) begin
                        phase_d  = PH_GREEN;
                        active_d = next_way;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    phase_d  = PH_GREEN;
                    active_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
        lights_d = decode_lights(phase_d, active_d);
    end

    // State and output registers; reset forces way 0 green immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_GREEN;
            active_q <= '0;
            timer_q  <= '0;
            lights_q <= decode_lights(PH_GREEN, '0);
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            lights_q <= lights_d;
        end
    end

    assign lights     = lights_q;
    assign active_way = active_q;
    assign phase      = phase_q;

endmodule
